// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid) with a registered ready, so upstream
// never sees a combinational path from out_ready_i. Supports flush-to-bubble.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        occ_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [1:0]        occ_q,        occ_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid_i & in_ready_q;
    assign out_xfer = main_valid_q & out_ready_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            main_valid_d = 1'b0;
            main_data_d  = FLUSH_VAL;
            skid_valid_d = 1'b0;
            skid_data_d  = FLUSH_VAL;
        end else if (main_valid_q) begin
            if (out_xfer) begin
                if (skid_valid_q) begin
                    // Ready was low, so no input can arrive this cycle.
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    main_data_d = in_data_i;
                end else begin
                    // Drained with no refill: data is kept, only valid drops.
                    main_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                skid_data_d  = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else if (in_xfer) begin
            main_data_d  = in_data_i;
            main_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
        occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_i) begin
            // NOTE: data entries are reset too, because the bubble value must be visible after reset.
            main_valid_q <= 1'b0;
            main_data_q  <= FLUSH_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= FLUSH_VAL;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign occ_o       = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised-handshake bench for pipe_stage_skid.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pipe_stage_skid;

    localparam int unsigned       DATA_W = 64;
    localparam logic [DATA_W-1:0] FV     = 64'hDEAD_0000_0000_BEEF;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;
    logic [1:0]        occ_o;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .FLUSH_VAL(FV)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .occ_o       (occ_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_state(input string name, input logic vld, input logic [DATA_W-1:0] dat,
                                input logic [1:0] occ, input logic rdy);
        checks++;
        if (out_valid_o !== vld || out_data_o !== dat || occ_o !== occ || in_ready_o !== rdy) begin
            errors++;
            $display("FAIL %s: got vld=%b data=%h occ=%0d rdy=%b, expected vld=%b data=%h occ=%0d rdy=%b",
                     name, out_valid_o, out_data_o, occ_o, in_ready_o, vld, dat, occ, rdy);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
        step(); step();
        expect_state("reset", 1'b0, FV, 2'd0, 1'b1);
        rst_i = 1'b0;
        step();
        expect_state("idle_after_reset", 1'b0, FV, 2'd0, 1'b1);
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 64'(i);
            step();
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== 64'(i) || occ_o > 2'd1 || in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got vld=%b data=%h occ=%0d rdy=%b, expected vld=1 data=%h occ<=1 rdy=1",
                         i, out_valid_o, out_data_o, occ_o, in_ready_o, 64'(i));
            end
        end
        in_valid_i = 1'b0;
        step();
        expect_state("stream_drained", 1'b0, 64'h8, 2'd0, 1'b1);
    endtask

    task automatic test_stall_fill();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 64'hA;
        step();
        expect_state("stall_a", 1'b1, 64'hA, 2'd1, 1'b1);
        in_data_i = 64'hB;
        step();
        expect_state("stall_b", 1'b1, 64'hA, 2'd2, 1'b0);
        in_data_i = 64'hC;
        step();
        expect_state("stall_c_held_off", 1'b1, 64'hA, 2'd2, 1'b0);
        step();
        expect_state("stall_hold", 1'b1, 64'hA, 2'd2, 1'b0);
        out_ready_i = 1'b1;
        step();
        expect_state("drain_b", 1'b1, 64'hB, 2'd1, 1'b1);
        step();
        expect_state("drain_c", 1'b1, 64'hC, 2'd1, 1'b1);
        in_valid_i = 1'b0;
        step();
        expect_state("drain_empty", 1'b0, 64'hC, 2'd0, 1'b1);
    endtask

    task automatic fill_two(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = a;
        step();
        in_data_i = b;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic test_flush();
        fill_two(64'h11, 64'h22);
        expect_state("flush_prefill", 1'b1, 64'h11, 2'd2, 1'b0);
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 64'hF;
        out_ready_i = 1'b1;
        step();
        expect_state("flush", 1'b0, FV, 2'd0, 1'b1);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_state("flush_no_0xF", 1'b0, FV, 2'd0, 1'b1);
        end
        // Flush while main alone is full and an input is offered: input must be dropped.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 64'h44;
        step();
        flush_i   = 1'b1;
        in_data_i = 64'h55;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        expect_state("flush_one_entry", 1'b0, FV, 2'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        fill_two(64'h31, 64'h32);
        expect_state("rst_prefill", 1'b1, 64'h31, 2'd2, 1'b0);
        rst_i       = 1'b1;
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = 64'h33;
        out_ready_i = 1'b1;
        step();
        expect_state("reset_mid", 1'b0, FV, 2'd0, 1'b1);
        rst_i     = 1'b0;
        flush_i   = 1'b0;
        in_data_i = 64'h5;
        step();
        expect_state("post_reset_first", 1'b1, 64'h5, 2'd1, 1'b1);
        in_valid_i = 1'b0;
        step();
        expect_state("post_reset_drain", 1'b0, 64'h5, 2'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] q[$];
        logic [DATA_W-1:0] held;
        logic              stalled;
        logic [DATA_W-1:0] next_val = 64'h1000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid_i  = ($urandom_range(0, 99) < 60);
            out_ready_i = ($urandom_range(0, 99) < 50);
            in_data_i   = next_val;
            stalled     = out_valid_o & ~out_ready_i;
            held        = out_data_o;
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_order cyc %0d: got data=%h, expected no valid output", cyc, out_data_o);
                end else begin
                    if (out_data_o !== q[0]) begin
                        errors++;
                        $display("FAIL rand_order cyc %0d: got data=%h, expected %h", cyc, out_data_o, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) begin
                q.push_back(next_val);
                next_val++;
            end
            step();
            checks++;
            if (occ_o !== 2'(q.size()) || in_ready_o !== (occ_o < 2'd2) || out_valid_o !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_state cyc %0d: got occ=%0d rdy=%b vld=%b, expected occ=%0d rdy=%b vld=%b",
                         cyc, occ_o, in_ready_o, out_valid_o, q.size(), (q.size() < 2), (q.size() != 0));
            end
            if (stalled) begin
                checks++;
                if (out_data_o !== held) begin
                    errors++;
                    $display("FAIL rand_stall cyc %0d: got data=%h, expected %h", cyc, out_data_o, held);
                end
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i rises on the sampling edge, and rst_i is sampled only on the rising edge of clk_i.
REQ-002 Parameter DATA_W, default 64, SHALL set the payload width in bits (for example, a 32-bit PC plus a 32-bit instruction), and SHALL be 1 or greater.
REQ-003 Parameter FLUSH_VAL, default {DATA_W{1'b0}}, SHALL be the payload value loaded on reset or flush (bubble/NOP encoding).
REQ-004 clk_i  input  1  clock.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 flush_i  input  1  synchronous discard of all held entries (branch/jump kill).
REQ-007 in_valid_i  input  1  upstream presents a payload.
REQ-008 in_data_i  input  DATA_W  upstream payload.
REQ-009 in_ready_o  output  1  stage can accept a payload this cycle; it SHALL be driven from a register.
REQ-010 out_valid_o  output  1  out_data_o holds a valid payload.
REQ-011 out_data_o  output  DATA_W  head payload, driven from a register.
REQ-012 out_ready_i  input  1  downstream consumes the head this cycle (a low value is a stall).
REQ-013 occ_o  output  2  number of held entries (0, 1 or 2).

Function
REQ-014 Storage SHALL be two entries: a main entry (drives the outputs) and a skid entry, each with its own valid bit.
REQ-015 An input transfer SHALL occur on a rising edge where in_valid_i=1 and in_ready_o=1; an output transfer SHALL occur where out_valid_o=1 and out_ready_i=1.
REQ-016 in_ready_o SHALL be 1 exactly when the skid entry is empty, and SHALL NOT depend combinationally on out_ready_i.
REQ-017 When main is empty, an accepted input SHALL load main; out_valid_o SHALL rise on the following cycle (1-cycle latency).
REQ-018 When main is full and an output transfer and an input transfer both occur with skid empty, the input SHALL load main directly.
REQ-019 When main is full, no output transfer occurs and an input is accepted, the input SHALL load the skid entry; in_ready_o SHALL drop on the next cycle.
REQ-020 When skid is full and an output transfer occurs, skid SHALL move to main, skid SHALL become empty, and in_ready_o SHALL rise on the next cycle.
REQ-021 With out_ready_i held at 1 and in_valid_i held at 1, throughput SHALL be one payload per cycle with no bubbles.
REQ-022 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped, except by flush or reset.
REQ-023 While out_valid_o=1 and out_ready_i=0, out_data_o SHALL hold stable.
REQ-024 occ_o SHALL equal main valid plus skid valid, registered, and SHALL never exceed 2.
REQ-025 flush_i=1 SHALL clear both valid bits and load FLUSH_VAL into both data entries.
REQ-026 Any input presented in a flush cycle SHALL be discarded, and any output transfer in that cycle SHALL still count as consumed downstream.
REQ-027 After a flush, the next cycle SHALL show out_valid_o=0, occ_o=0 and in_ready_o=1.
REQ-028 Priority SHALL be: rst_i first, then flush_i, then normal transfers.
REQ-029 When main becomes empty through an output transfer with no refill, out_data_o SHALL retain its last value; only reset and flush force FLUSH_VAL.

Reset
REQ-030 While rst_i=1 at a rising edge, the next state SHALL be: out_valid_o=0, out_data_o=FLUSH_VAL, skid empty, occ_o=0, in_ready_o=1.
REQ-031 Reset asserted mid-operation SHALL discard both entries regardless of flush_i, in_valid_i and out_ready_i.
REQ-032 The first input transfer SHALL be possible in the first cycle after rst_i deasserts.

Verification
REQ-033 Streaming: DATA_W=64; send 0x1..0x8 on consecutive cycles with out_ready_i=1 -> out_data_o shows 0x1..0x8 on consecutive cycles one cycle later, and occ_o never exceeds 1.
REQ-034 Stall fill: hold out_ready_i=0 and send 0xA, 0xB, 0xC -> 0xA and 0xB are accepted, 0xC is held off by in_ready_o=0, and occ_o=2. Then raise out_ready_i -> output is 0xA, 0xB, 0xC in order, with no loss.
REQ-035 Flush with full stage: occ_o=2, then flush_i=1 together with in_valid_i=1 and data 0xF -> next cycle out_valid_o=0, out_data_o=FLUSH_VAL, occ_o=0, in_ready_o=1, and 0xF never appears.
REQ-036 Reset mid-stream: with occ_o=2, assert rst_i and flush_i together for one cycle -> identical to the REQ-030 state. A fresh 0x5 accepted the next cycle appears on the output one cycle later.
REQ-037 Randomised handshake: random in_valid_i and out_ready_i over 10k cycles -> the output sequence equals the accepted-input sequence, out_data_o is stable during stalls, and in_ready_o==(occ_o<2 or skid empty) holds every cycle.
